// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request side and a valid/ready
// response side. Simple ops finish in one cycle. MULU, DIVU and REMU iterate
// one bit per cycle for XLEN cycles. Only one operation is in flight at a time.
module alu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            cin_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            cflag_o,
  output logic            vflag_o,
  output logic            zflag_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;
  localparam logic [3:0] OP_REMU = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            c;
    logic            v;
  } alu_out_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             multi;
  logic             last_iter;
  logic [SHW-1:0]   cnt;

  // Iterative datapath state (multiply and divide share the captured opcode).
  logic [3:0]       op_q;
  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  acc;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  rem;
  logic [XLEN-1:0]  divisor;

  logic [XLEN-1:0]  acc_step;
  logic [XLEN:0]    rem_shift;
  logic [XLEN:0]    diff;
  logic [XLEN-1:0]  rem_step;
  logic [XLEN-1:0]  quo_step;
  logic [XLEN-1:0]  iter_res;
  alu_out_t         single;

  // Single-cycle ops. SUB/SLT/SLTU all run through the adder as A + ~B + 1,
  // so the compares report the subtraction flags.
  function automatic alu_out_t alu_fn(input logic [3:0]      op,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b,
                                      input logic            cin);
    alu_out_t               o;
    logic [XLEN-1:0]        bb;
    logic                   ci;
    logic [XLEN:0]          sum;
    logic                   c;
    logic                   v;
    logic signed [XLEN-1:0] sa;
    logic [SHW-1:0]         shamt;
    bb    = (op == OP_ADD) ? b : ~b;
    ci    = (op == OP_ADD) ? cin : 1'b1;
    sum   = {1'b0, a} + {1'b0, bb} + {{XLEN{1'b0}}, ci};
    c     = sum[XLEN];
    // Same-sign operands producing a different-sign sum is exactly
    // carry-into-MSB xor carry-out-of-MSB.
    v     = (a[XLEN-1] == bb[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
    sa    = a;
    shamt = b[SHW-1:0];
    o     = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        o.res = sum[XLEN-1:0];
        o.c   = c;
        o.v   = v;
      end
      OP_AND: o.res = a & b;
      OP_XOR: o.res = a ^ b;
      OP_SLL: o.res = a << shamt;
      OP_SRL: o.res = a >> shamt;
      OP_SRA: o.res = sa >>> shamt;
      OP_SLTU: begin
        o.res = {{(XLEN-1){1'b0}}, ~c};
        o.c   = c;
        o.v   = v;
      end
      OP_SLT: begin
        o.res = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ v};
        o.c   = c;
        o.v   = v;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  assign accept    = req_valid_i & req_ready_o;
  assign multi     = (op_i == OP_MULU) || (op_i == OP_DIVU) || (op_i == OP_REMU);
  assign last_iter = (state == BUSY) && (cnt == SHW'(XLEN - 1));
  assign single    = alu_fn(op_i, a_i, b_i, cin_i);

  // One shift-add step and one restoring-division step per BUSY cycle.
  // With a zero divisor every trial subtraction succeeds, which leaves the
  // quotient all ones and shifts the whole dividend into the remainder.
  always_comb begin
    acc_step  = mplier[0] ? (acc + mcand) : acc;
    rem_shift = {1'b0, rem[XLEN-1:0], quo[XLEN-1]};
    rem_shift = {rem, quo[XLEN-1]};
    diff      = rem_shift - {1'b0, divisor};
    rem_step  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    quo_step  = {quo[XLEN-2:0], ~diff[XLEN]};
    case (op_q)
      OP_MULU: iter_res = acc_step;
      OP_DIVU: iter_res = quo_step;
      default: iter_res = rem_step;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; rsp_ready_i only matters in DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = multi ? BUSY : DONE;
      BUSY:    if (last_iter) state_next = DONE;
      DONE:    if (rsp_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    req_ready_o = (state == IDLE);
    rsp_valid_o = (state == DONE);
  end

  // Iteration counter and registered result/flags, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt      <= '0;
      result_o <= '0;
      cflag_o  <= 1'b0;
      vflag_o  <= 1'b0;
      zflag_o  <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      if (!multi) begin
        result_o <= single.res;
        cflag_o  <= single.c;
        vflag_o  <= single.v;
        zflag_o  <= (single.res == '0);
      end
    end else if (state == BUSY) begin
      cnt <= cnt + SHW'(1);
      if (last_iter) begin
        result_o <= iter_res;
        cflag_o  <= 1'b0;
        vflag_o  <= 1'b0;
        zflag_o  <= (iter_res == '0);
      end
    end
  end

  // Operand capture on accept and per-cycle multiply/divide iteration.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      op_q    <= op_i;
      mcand   <= a_i;
      mplier  <= b_i;
      acc     <= '0;
      quo     <= a_i;
      rem     <= '0;
      divisor <= b_i;
    end else if (state == BUSY) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_step;
      quo    <= quo_step;
      rem    <= rem_step;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed vector table on a 64-bit instance, plus
// hand-written sequences for DONE holding, reset mid-BUSY and an 8-bit instance.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, cin;
  logic        cflag, vflag, zflag;
  logic [3:0]  op;
  logic [63:0] a, b, result;

  logic        req_valid8, req_ready8, rsp_valid8, rsp_ready8, cin8;
  logic        cflag8, vflag8, zflag8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, result8;

  int   total = 0;
  int   bad   = 0;
  logic sel8  = 1'b0;

  alu_seq #(.XLEN(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .a_i(a), .b_i(b), .cin_i(cin),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .result_o(result), .cflag_o(cflag), .vflag_o(vflag), .zflag_o(zflag)
  );

  alu_seq #(.XLEN(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid8), .req_ready_o(req_ready8),
    .op_i(op8), .a_i(a8), .b_i(b8), .cin_i(cin8),
    .rsp_valid_o(rsp_valid8), .rsp_ready_i(rsp_ready8),
    .result_o(result8), .cflag_o(cflag8), .vflag_o(vflag8), .zflag_o(zflag8)
  );

  // View of whichever instance is selected.
  logic        v_rdy, v_vld, v_c, v_v, v_z;
  logic [63:0] v_res;
  assign v_rdy = sel8 ? req_ready8 : req_ready;
  assign v_vld = sel8 ? rsp_valid8 : rsp_valid;
  assign v_c   = sel8 ? cflag8 : cflag;
  assign v_v   = sel8 ? vflag8 : vflag;
  assign v_z   = sel8 ? zflag8 : zflag;
  assign v_res = sel8 ? {56'd0, result8} : result;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [3:0] o, input logic [63:0] aa, input logic [63:0] bb,
                                  input logic ci, input logic [63:0] r, input logic c, input logic v,
                                  input logic z, input int lat);
    vec_t t;
    t.op = o; t.a = aa; t.b = bb; t.cin = ci;
    t.res = r; t.c = c; t.v = v; t.z = z; t.lat = lat;
    vecs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [3:0] o, input logic [63:0] aa,
                       input logic [63:0] bb, input logic ci);
    if (sel8) begin
      req_valid8 = vld; op8 = o; a8 = aa[7:0]; b8 = bb[7:0]; cin8 = ci;
    end else begin
      req_valid = vld; op = o; a = aa; b = bb; cin = ci;
    end
  endtask

  task automatic set_rsp_ready(input logic r);
    if (sel8) rsp_ready8 = r;
    else      rsp_ready  = r;
  endtask

  // Issue one request, scramble the inputs right after accept, wait (bounded)
  // for the response, sample it, then hand it back with rsp_ready.
  task automatic do_op(input logic [3:0] o, input logic [63:0] aa, input logic [63:0] bb,
                       input logic ci, output logic [63:0] res, output logic c,
                       output logic v, output logic z, output int lat, output logic busy_rdy);
    @(posedge clk); #1;
    drive(1'b1, o, aa, bb, ci);
    @(posedge clk); #1;
    drive(1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    lat = 1;
    busy_rdy = 1'b0;
    while (!v_vld && lat < 200) begin
      if (v_rdy) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    res = v_res; c = v_c; v = v_v; z = v_z;
    set_rsp_ready(1'b1);
    @(posedge clk); #1;
    set_rsp_ready(1'b0);
  endtask

  logic [63:0] r;
  logic        fc, fv, fz, brdy;
  int          lat;

  initial begin
    rst_n = 1'b0;
    req_valid = 0; op = 0; a = 0; b = 0; cin = 0; rsp_ready = 0;
    req_valid8 = 0; op8 = 0; a8 = 0; b8 = 0; cin8 = 0; rsp_ready8 = 0;

    //        op     a                      b                      cin result                 C  V  Z  lat
    add_vec(4'd0,  64'h7FFF_FFFF_FFFF_FFFF, 64'd1,                 0, 64'h8000_0000_0000_0000, 0, 1, 0, 1);
    add_vec(4'd1,  64'd5,                  64'd5,                 0, 64'd0,                  1, 0, 1, 1);
    add_vec(4'd8,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 0, 64'd1,                  1, 0, 0, 1);
    add_vec(4'd7,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 0, 64'd0,                  1, 0, 1, 1);
    add_vec(4'd9,  64'd7,                  64'd6,                 0, 64'd42,                 0, 0, 0, 65);
    add_vec(4'd10, 64'd100,                64'd0,                 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 65);
    add_vec(4'd11, 64'd100,                64'd7,                 0, 64'd2,                  0, 0, 0, 65);
    add_vec(4'd6,  64'h8000_0000_0000_0000, 64'h43,                0, 64'hF000_0000_0000_0000, 0, 0, 0, 1);
    add_vec(4'd0,  64'd1,                  64'd2,                 1, 64'd4,                  0, 0, 0, 1);
    add_vec(4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1,                 0, 64'd0,                  1, 0, 1, 1);
    add_vec(4'd1,  64'd3,                  64'd5,                 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1);
    add_vec(4'd1,  64'h8000_0000_0000_0000, 64'd1,                 0, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 1);
    add_vec(4'd2,  64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 0, 64'h00F0_00F0_00F0_00F0, 0, 0, 0, 1);
    add_vec(4'd3,  64'h1234,               64'h1234,              0, 64'd0,                  0, 0, 1, 1);
    add_vec(4'd4,  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 1);
    add_vec(4'd5,  64'h8000_0000_0000_0000, 64'h43,                0, 64'h1000_0000_0000_0000, 0, 0, 0, 1);
    add_vec(4'd8,  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd0,                  0, 0, 1, 1);
    add_vec(4'd7,  64'd1,                  64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd1,                  0, 0, 0, 1);
    add_vec(4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'd1,                  0, 0, 0, 65);
    add_vec(4'd9,  64'd0,                  64'd5,                 0, 64'd0,                  0, 0, 1, 65);
    add_vec(4'd10, 64'd100,                64'd7,                 0, 64'd14,                 0, 0, 0, 65);
    add_vec(4'd11, 64'd100,                64'd0,                 0, 64'd100,                0, 0, 0, 65);
    add_vec(4'd12, 64'd5,                  64'd5,                 1, 64'd0,                  0, 0, 1, 1);
    add_vec(4'd15, 64'hFFFF,               64'd1,                 0, 64'd0,                  0, 0, 1, 1);

    // Reset state
    #1;
    check("rst rsp_valid", rsp_valid, 0);
    check("rst result", result, 0);
    check("rst flags", {cflag, vflag, zflag}, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("rst req_ready", req_ready, 1);
    check("rst rsp_valid8", rsp_valid8, 0);

    // Vector table
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, r, fc, fv, fz, lat, brdy);
      check($sformatf("v%0d result", i), r, vecs[i].res);
      check($sformatf("v%0d cflag", i), fc, vecs[i].c);
      check($sformatf("v%0d vflag", i), fv, vecs[i].v);
      check($sformatf("v%0d zflag", i), fz, vecs[i].z);
      check($sformatf("v%0d latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d busy req_ready", i), brdy, 0);
    end

    // rsp_ready in IDLE has no effect
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle rsp_ready rsp_valid", rsp_valid, 0);
    check("idle rsp_ready req_ready", req_ready, 1);
    rsp_ready = 1'b0;

    // DONE held 10 cycles with a competing request present
    drive(1'b1, 4'd0, 64'd1, 64'd2, 1'b0);
    @(posedge clk); #1;
    drive(1'b1, 4'd1, 64'd9, 64'd4, 1'b0);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("hold%0d result", k), result, 64'd3);
      check($sformatf("hold%0d rsp_valid", k), rsp_valid, 1);
      check($sformatf("hold%0d req_ready", k), req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("release rsp_valid", rsp_valid, 0);
    check("release req_ready", req_ready, 1);
    check("release result", result, 64'd3);
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);

    // Reset in the middle of a multiply
    @(posedge clk); #1;
    drive(1'b1, 4'd9, 64'd7, 64'd6, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 4'd0, 64'd0, 64'd0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("busy req_ready", req_ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst rsp_valid", rsp_valid, 0);
    check("midrst result", result, 0);
    check("midrst req_ready", req_ready, 1);
    #2;
    rst_n = 1'b1;
    do_op(4'd9, 64'd7, 64'd6, 1'b0, r, fc, fv, fz, lat, brdy);
    check("post rst mulu result", r, 64'd42);
    check("post rst mulu latency", lat, 65);
    do_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, r, fc, fv, fz, lat, brdy);
    check("post rst add result", r, 64'h8000_0000_0000_0000);
    check("post rst add vflag", fv, 1);

    // 8-bit instance
    sel8 = 1'b1;
    do_op(4'd9, 64'h10, 64'h10, 1'b0, r, fc, fv, fz, lat, brdy);
    check("x8 mulu result", r, 64'h00);
    check("x8 mulu latency", lat, 9);
    check("x8 mulu zflag", fz, 1);
    check("x8 mulu busy req_ready", brdy, 0);
    do_op(4'd0, 64'hFF, 64'h01, 1'b0, r, fc, fv, fz, lat, brdy);
    check("x8 add result", r, 64'h00);
    check("x8 add cflag", fc, 1);
    check("x8 add vflag", fv, 0);
    check("x8 add zflag", fz, 1);
    check("x8 add latency", lat, 1);
    do_op(4'd10, 64'hC8, 64'h0A, 1'b0, r, fc, fv, fz, lat, brdy);
    check("x8 divu result", r, 64'h14);
    check("x8 divu latency", lat, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 64, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Derived constant SHW = log2(XLEN), shift-amount width; not overridable.
REQ-003 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n_i  input  1  asynchronous, active-low reset.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  block can accept request.
REQ-007 op_i  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 SLL, 5 SRL, 6 SRA, 7 SLTU, 8 SLT, 9 MULU, 10 DIVU, 11 REMU; 12-15 reserved.
REQ-008 a_i  input  XLEN  operand A.
REQ-009 b_i  input  XLEN  operand B / shift amount.
REQ-010 cin_i  input  1  carry-in for ADD only.
REQ-011 rsp_valid_o  output  1  result present.
REQ-012 rsp_ready_i  input  1  consumer takes result.
REQ-013 result_o  output  XLEN  registered result.
REQ-014 cflag_o, vflag_o, zflag_o  output  1 each  registered carry, signed overflow, zero.

Function
REQ-015 FSM states IDLE, BUSY, DONE; req_ready_o SHALL be 1 only in IDLE; one operation in flight max.
REQ-016 Accept = req_valid_i & req_ready_o; op_i, a_i, b_i, cin_i SHALL be captured on accept; later input changes have no effect.
REQ-017 Ops 0-8 and 12-15: IDLE -> DONE on accept; rsp_valid_o = 1 the cycle after accept (latency 1).
REQ-018 Ops 9-11: IDLE -> BUSY on accept; BUSY lasts exactly XLEN cycles (one bit per cycle, counter 0..XLEN-1); BUSY -> DONE after last iteration; rsp_valid_o asserted XLEN+1 cycles after accept.
REQ-019 DONE: rsp_valid_o = 1, result_o and flags held stable until rsp_ready_i = 1; DONE -> IDLE on that edge; no new request accepted in the same cycle (back-to-back throughput one op per latency+1 cycles).
REQ-020 ADD: A + B + cin_i mod 2^XLEN; SUB: A + ~B + 1; cflag_o = carry out of bit XLEN-1 (SUB: 1 means no borrow); vflag_o = carry into MSB XOR carry out of MSB.
REQ-021 AND, XOR: bitwise; SLL/SRL/SRA shift A by b_i[SHW-1:0], upper B bits ignored; SRA replicates A[XLEN-1].
REQ-022 SLTU: result = 1 if A < B unsigned else 0; SLT: signed compare; computed via SUB (SLT = sum MSB XOR V; SLTU = ~C); upper bits zero.
REQ-023 MULU: low XLEN bits of unsigned A*B via shift-add; high product bits discarded.
REQ-024 DIVU/REMU: restoring unsigned division, quotient / remainder respectively.
REQ-025 Divide by zero: DIVU result all ones, REMU result = A; no extra cycles, no error flag.
REQ-026 zflag_o = 1 iff result_o == 0, for every op; cflag_o, vflag_o = 0 for all ops other than ADD, SUB, SLT, SLTU (those report SUB/ADD flags).
REQ-027 Reserved opcodes: result 0, zflag_o 1, cflag_o/vflag_o 0, latency 1.
REQ-028 rsp_ready_i while not DONE SHALL be ignored.

Reset
REQ-029 rst_n_i low SHALL immediately force IDLE, counter 0, rsp_valid_o 0, result_o 0, all flags 0, req_ready_o 1 once released; applies mid-BUSY and mid-DONE, in-flight op discarded.
REQ-030 First accept possible on the first rising edge with rst_n_i high.

Verification (XLEN = 64 unless noted)
REQ-031 ADD a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> after 1 cycle result 0x8000_0000_0000_0000, V=1, C=0, Z=0.
REQ-032 SUB a=5, b=5 -> result 0, Z=1, C=1; SLT a=-1, b=1 -> 1; SLTU a=-1, b=1 -> 0.
REQ-033 MULU a=7, b=6 -> rsp_valid_o exactly 65 cycles after accept, result 42; req_ready_o 0 throughout.
REQ-034 DIVU a=100, b=0 -> all ones; REMU a=100, b=7 -> 2; SRA a=0x8000_0000_0000_0000, b=0x43 -> 0xF000_0000_0000_0000.
REQ-035 Hold rsp_ready_i=0 for 10 cycles in DONE -> outputs stable, req_valid_i ignored; reset asserted mid-BUSY -> rsp_valid_o 0 immediately, next op correct.
REQ-036 XLEN=8: MULU 0x10*0x10 -> 0x00, latency 9; ADD 0xFF+0x01 -> 0x00, C=1, Z=1.
